// File: rtl/firebird7_in_gate2_ijtag_csu_seq.sv
// IJTAG CSU access sequencer: one request runs CAPTURE, SHIFT (eff_len cycles), UPDATE, then holds the response.
// Optional access counter output enabled by macro FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN.
module firebird7_in_gate2_ijtag_csu_seq #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              ijtag_sel,
  output logic              ijtag_ce,
  output logic              ijtag_se,
  output logic              ijtag_ue,
  output logic              ijtag_si,
  input  logic              ijtag_so
`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
  ,
  output logic [15:0]       access_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, RESP} state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] mask_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  eff_len;

  always_comb begin
    eff_len = (int'(req_len) > DATA_W) ? CNT_W'(DATA_W) : CNT_W'(req_len);
  end

  // data_reg shifts right so si always comes from bit 0; mask_reg marks the resp_data bit of the current shift cycle
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_reg  <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      ijtag_sel  <= 1'b0;
      ijtag_ce   <= 1'b0;
      ijtag_se   <= 1'b0;
      ijtag_ue   <= 1'b0;
      ijtag_si   <= 1'b0;
      data_reg   <= '0;
      mask_reg   <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            data_reg  <= req_data;
            len_reg   <= eff_len;
            cnt_reg   <= '0;
            mask_reg  <= DATA_W'(1);
            resp_data <= '0;
            req_ready <= 1'b0;
            ijtag_sel <= 1'b1;
            ijtag_ce  <= 1'b1;
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          ijtag_ce <= 1'b0;
          if (len_reg != '0) begin
            ijtag_se  <= 1'b1;
            ijtag_si  <= data_reg[0];
            data_reg  <= data_reg >> 1;
            state_reg <= SHIFT;
          end else begin
            ijtag_ue  <= 1'b1;
            state_reg <= UPDATE;
          end
        end
        SHIFT: begin
          resp_data <= resp_data | (ijtag_so ? mask_reg : '0);
          mask_reg  <= mask_reg << 1;
          if (cnt_reg + CNT_W'(1) == len_reg) begin
            ijtag_se  <= 1'b0;
            ijtag_si  <= 1'b0;
            ijtag_ue  <= 1'b1;
            state_reg <= UPDATE;
          end else begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            ijtag_si <= data_reg[0];
            data_reg <= data_reg >> 1;
          end
        end
        UPDATE: begin
          ijtag_ue   <= 1'b0;
          ijtag_sel  <= 1'b0;
          resp_valid <= 1'b1;
          state_reg  <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
  logic [15:0] access_cnt_reg;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      access_cnt_reg <= '0;
    end else if (state_reg == RESP && resp_ready && access_cnt_reg != 16'hFFFF) begin
      access_cnt_reg <= access_cnt_reg + 16'd1;
    end
  end

  assign access_cnt = access_cnt_reg;
`endif

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_csu_seq.sv
// Self-checking bench for the IJTAG CSU sequencer: vector table, SIB network scenario, mid-shift reset, random accesses.
module tb_firebird7_in_gate2_ijtag_csu_seq;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [LEN_W-1:0]  req_len = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_data;
  logic              sel, ce, se, ue, si;
  logic              so;
  logic              so_drv = 1'b0;
  logic              use_net = 1'b0;
  logic              net_rst = 1'b1;
  logic              net_so;
`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
  logic [15:0]       access_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_access = 0;

  always #5 clk = ~clk;

  firebird7_in_gate2_ijtag_csu_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .ijtag_tck(clk), .ijtag_reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .ijtag_sel(sel), .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si),
    .ijtag_so(so)
`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
    , .access_cnt(access_cnt)
`endif
  );

  // Behavioural network: one SIB whose 8-bit segment sits between the SIB cell and scan-out when open
  logic       sib_sr, sib_open;
  logic [7:0] seg;
  assign net_so = sib_open ? seg[0] : sib_sr;
  assign so = use_net ? net_so : so_drv;

  always @(posedge clk) begin
    if (net_rst) begin
      sib_sr <= 1'b0; sib_open <= 1'b0; seg <= 8'h00;
    end else if (sel) begin
      if (ce) begin
        sib_sr <= sib_open; seg <= 8'h5A;
      end else if (se) begin
        if (sib_open) seg <= {sib_sr, seg[7:1]};
        sib_sr <= si;
      end else if (ue) begin
        sib_open <= sib_sr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // control vector order: {sel, ce, se, ue, si, req_ready, resp_valid}
  task automatic chk_ctl(input string name, input logic [6:0] exp);
    chk(name, {57'd0, sel, ce, se, ue, si, req_ready, resp_valid}, {57'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    req_valid = 1'($urandom_range(0, 1));
    req_data  = $urandom;
    req_len   = LEN_W'($urandom);
  endtask

  task automatic run_access(input int len, input logic [31:0] data, input logic [31:0] so_pat,
                            input int hold, input logic [31:0] exp, input string tag);
    int eff;
    eff = (len > DATA_W) ? DATA_W : len;
    chk({tag, " idle_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_len = LEN_W'(len); req_data = data; resp_ready = 1'b0;
    step();
    noise(); so_drv = 1'($urandom);
    chk_ctl({tag, " capture"}, 7'b1100000);
    step();
    for (int k = 0; k < eff; k++) begin
      noise(); so_drv = so_pat[k];
      chk_ctl({tag, $sformatf(" shift%0d", k)}, {5'b10100 | {4'b0, data[k]}, 2'b00});
      step();
    end
    noise(); so_drv = 1'($urandom);
    chk_ctl({tag, " update"}, 7'b1001000);
    step();
    for (int h = 0; h <= hold; h++) begin
      noise();
      resp_ready = (h == hold);
      chk_ctl({tag, $sformatf(" resp%0d", h)}, 7'b0000001);
      chk({tag, " resp_data"}, {32'd0, resp_data}, {32'd0, exp});
      step();
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    chk_ctl({tag, " back_idle"}, 7'b0000010);
    n_access++;
`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
    chk({tag, " access_cnt"}, {48'd0, access_cnt}, (n_access > 65535) ? 64'hFFFF : 64'(n_access));
`endif
    $display("[TB] access %s len=%0d data=0x%08h exp=0x%08h got=0x%08h", tag, len, data, exp, resp_data);
  endtask

  typedef struct {
    int          len;
    logic [31:0] data;
    logic [31:0] so_pat;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4,  32'h0000000A, 32'h0000000B, 0, 32'h0000000B};
    tbl[1] = '{0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000};
    tbl[2] = '{40, 32'h12345678, 32'hDEADBEEF, 5, 32'hDEADBEEF};
    tbl[3] = '{32, 32'h80000001, 32'h80000001, 0, 32'h80000001};
    tbl[4] = '{1,  32'h00000001, 32'h00000000, 2, 32'h00000000};
    tbl[5] = '{33, 32'hCAFEF00D, 32'h0F0F0F0F, 0, 32'h0F0F0F0F};
    tbl[6] = '{31, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h7FFFFFFF};
    tbl[7] = '{63, 32'h5A5A5A5A, 32'hA5A5A5A5, 1, 32'hA5A5A5A5};

    step(); step();
    chk_ctl("reset ctl", 7'b0000010);
    chk("reset resp_data", {32'd0, resp_data}, 64'd0);
`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
    chk("reset access_cnt", {48'd0, access_cnt}, 64'd0);
`endif
    rst_n = 1'b1; net_rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_access(tbl[i].len, tbl[i].data, tbl[i].so_pat, tbl[i].hold, tbl[i].exp, $sformatf("vec%0d", i));

    // SIB opens on the first UPDATE; the second access sees segment 0x5A then the SIB bit at position 8
    use_net = 1'b1;
    run_access(1, 32'h1, 32'h0, 0, 32'h0, "sib_open");
    chk("sib opened", {63'd0, sib_open}, 64'd1);
    run_access(9, 32'h0, 32'h0, 0, 32'h0000015A, "sib_access");
    use_net = 1'b0;

    // Mid-shift reset
    so_drv = 1'b1;
    req_valid = 1'b1; req_len = LEN_W'(8); req_data = 32'hFF;
    step();
    req_valid = 1'b0;
    for (int t = 0; t < 4; t++) step();
    chk_ctl("midrst in shift3", 7'b1010100);
    rst_n = 1'b0;
    #1;
    chk_ctl("midrst ctl", 7'b0000010);
    chk("midrst resp_data", {32'd0, resp_data}, 64'd0);
    n_access = 0;
`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
    chk("midrst access_cnt", {48'd0, access_cnt}, 64'd0);
`endif
    for (int t = 0; t < 2; t++) begin
      step();
      chk_ctl("midrst hold", 7'b0000010);
    end
    rst_n = 1'b1;
    run_access(6, 32'h2D, 32'h15, 1, 32'h15, "post_rst");

    // Random accesses against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      int          len, hold, eff;
      logic [31:0] d, s, e;
      logic [63:0] m;
      len  = $urandom_range(0, 63);
      hold = $urandom_range(0, 3);
      d = $urandom; s = $urandom;
      eff = (len > DATA_W) ? DATA_W : len;
      m = (64'd1 << eff) - 64'd1;
      e = s & m[31:0];
      run_access(len, d, s, hold, e, $sformatf("rnd%0d", i));
    end

`ifdef FIREBIRD7_CSU_SEQ_ACCESS_CNT_EN
    force dut.access_cnt_reg = 16'hFFFF;
    step();
    release dut.access_cnt_reg;
    n_access = 65535;
    run_access(2, 32'h3, 32'h1, 0, 32'h1, "cnt_sat");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
